// File: rtl/uc_pkg.sv
// Shared types and encodings for the multi-cycle RV64I control unit.
// The TRAP state exists only when UC_TRAP_EN is defined.
package uc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
`ifdef UC_TRAP_EN
        ,
        TRAP   = 3'd6
`endif
    } state_t;

    typedef enum logic [2:0] {
        CL_R,
        CL_I,
        CL_LD,
        CL_ST,
        CL_BR,
        CL_JAL,
        CL_ILL
    } instr_class_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

endpackage

// File: rtl/uc_decode.sv
// Combinational instruction classifier: opcode/funct7[5] to instruction class
// and the ALU operand/operation selects used from EXEC onwards.
module uc_decode
    import uc_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic         funct7_5,
    output instr_class_t iclass,
    output logic         alu_src,
    output logic [1:0]   soma_ou_subtrai
);

    always_comb begin
        iclass          = CL_ILL;
        alu_src         = 1'b0;
        soma_ou_subtrai = ALU_ADD;
        case (opcode)
            OP_R: begin
                iclass = CL_R;
                if (funct7_5) soma_ou_subtrai = ALU_SUB;
            end
            OP_I: begin
                iclass  = CL_I;
                alu_src = 1'b1;
            end
            OP_LD: begin
                iclass  = CL_LD;
                alu_src = 1'b1;
            end
            OP_ST: begin
                iclass  = CL_ST;
                alu_src = 1'b1;
            end
            OP_BR: begin
                iclass          = CL_BR;
                soma_ou_subtrai = ALU_SUB;
            end
            OP_JAL:  iclass = CL_JAL;
            default: iclass = CL_ILL;
        endcase
    end

endmodule

// File: rtl/uc_multiciclo.sv
// Multi-cycle control FSM sequencing the RV64I datapath with handshaked memories.
// Optional UC_TRAP_EN: illegal opcodes lock into TRAP instead of executing as NOP.
//
// state  | meaning
// IDLE   | post-reset, one cycle with all outputs low
// FETCH  | imem_req held until imem_ack; IR loaded on the ack cycle
// DECODE | IR fields settle through the decoder
// EXEC   | ALU operates; branches and NOPs update PC here
// MEM    | dmem_req held until dmem_ack
// WB     | register write and PC update
// TRAP   | illegal instruction, held until reset (UC_TRAP_EN only)
module uc_multiciclo
    import uc_pkg::*;
#(
    parameter int PC_INC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_src,
    output logic       alu_src,
    output logic [1:0] soma_ou_subtrai,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       trap
);

    localparam logic [7:0] PC_INC_B = 8'(PC_INC);

    state_t       state, state_next;
    instr_class_t iclass;
    logic         dec_alu_src;
    logic [1:0]   dec_soma;

    // funct3 is reserved for future access-width decode; the PC adder lives in the datapath
    logic unused_fields;
    assign unused_fields = ^{funct3, funct7[6], funct7[4:0], PC_INC_B};

    uc_decode u_decode (
        .opcode          (opcode),
        .funct7_5        (funct7[5]),
        .iclass          (iclass),
        .alu_src         (dec_alu_src),
        .soma_ou_subtrai (dec_soma)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next      = state;
        imem_req        = 1'b0;
        ir_we           = 1'b0;
        pc_we           = 1'b0;
        pc_src          = 1'b0;
        alu_src         = 1'b0;
        soma_ou_subtrai = ALU_ADD;
        dmem_req        = 1'b0;
        dmem_we         = 1'b0;
        rf_we           = 1'b0;
        wb_sel          = WB_ALU;
        trap            = 1'b0;
        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we      = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
`ifdef UC_TRAP_EN
                state_next = (iclass == CL_ILL) ? TRAP : EXEC;
`else
                state_next = EXEC;
`endif
            end
            EXEC: begin
                alu_src         = dec_alu_src;
                soma_ou_subtrai = dec_soma;
                case (iclass)
                    CL_BR: begin
                        pc_we      = 1'b1;
                        pc_src     = zero;
                        state_next = FETCH;
                    end
                    CL_ILL: begin
                        pc_we      = 1'b1;
                        state_next = FETCH;
                    end
                    CL_LD, CL_ST: state_next = MEM;
                    default:      state_next = WB;
                endcase
            end
            MEM: begin
                alu_src         = dec_alu_src;
                soma_ou_subtrai = dec_soma;
                dmem_req        = 1'b1;
                dmem_we         = (iclass == CL_ST);
                if (dmem_ack) begin
                    if (iclass == CL_ST) begin
                        pc_we      = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end
            end
            WB: begin
                alu_src         = dec_alu_src;
                soma_ou_subtrai = dec_soma;
                rf_we           = 1'b1;
                pc_we           = 1'b1;
                pc_src          = (iclass == CL_JAL);
                if (iclass == CL_LD)       wb_sel = WB_MEM;
                else if (iclass == CL_JAL) wb_sel = WB_PC4;
                else                       wb_sel = WB_ALU;
                state_next = FETCH;
            end
`ifdef UC_TRAP_EN
            TRAP: trap = 1'b1;
`endif
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed, table-driven bench for uc_multiciclo: per-instruction latency and
// pulse accounting, plus hand sequences for reset-mid-MEM and illegal opcodes.
module tb_uc_multiciclo;
    import uc_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic       imem_ack;
    logic       dmem_ack;
    logic       imem_req, ir_we, pc_we, pc_src, alu_src;
    logic [1:0] soma_ou_subtrai;
    logic       dmem_req, dmem_we, rf_we;
    logic [1:0] wb_sel;
    logic       trap;
    logic [13:0] all_outs;

    int total = 0;
    int bad   = 0;

    int m_cyc, m_soma, m_alu, m_rf, m_wb, m_pcwe, m_pcsrc, m_dreq, m_dwe, m_irwe, m_trap;
    bit m_timeout;

    typedef struct {
        logic [6:0] op;
        logic [6:0] f7;
        logic       z;
        int iw;
        int dw;
        bit spur;
        int cyc;
        int soma;
        int alu;
        int rf;
        int wb;
        int pcwe;
        int pcsrc;
        int dreq;
        int dwe;
    } vec_t;

    vec_t vecs[$];

    uc_multiciclo #(.PC_INC(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .opcode          (opcode),
        .funct3          (funct3),
        .funct7          (funct7),
        .zero            (zero),
        .imem_ack        (imem_ack),
        .dmem_ack        (dmem_ack),
        .imem_req        (imem_req),
        .ir_we           (ir_we),
        .pc_we           (pc_we),
        .pc_src          (pc_src),
        .alu_src         (alu_src),
        .soma_ou_subtrai (soma_ou_subtrai),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .rf_we           (rf_we),
        .wb_sel          (wb_sel),
        .trap            (trap)
    );

    assign all_outs = {imem_req, ir_we, pc_we, pc_src, alu_src, soma_ou_subtrai,
                       dmem_req, dmem_we, rf_we, wb_sel, trap};

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [6:0] op, input logic [6:0] f7, input logic z,
                           input int iw, input int dw, input bit spur, input int cyc,
                           input int soma, input int alu, input int rf, input int wb,
                           input int pcwe, input int pcsrc, input int dreq, input int dwe);
        vec_t v;
        v.op = op; v.f7 = f7; v.z = z; v.iw = iw; v.dw = dw; v.spur = spur;
        v.cyc = cyc; v.soma = soma; v.alu = alu; v.rf = rf; v.wb = wb;
        v.pcwe = pcwe; v.pcsrc = pcsrc; v.dreq = dreq; v.dwe = dwe;
        vecs.push_back(v);
    endtask

    // Entered at a negedge while the DUT sits in its first FETCH cycle; returns
    // just after the negedge of the next FETCH entry.
    task automatic run_instr(input logic [6:0] op, input logic [6:0] f7, input logic z,
                             input int iw, input int dw, input bit spur);
        int  icnt = 0;
        int  dcnt = 0;
        bit  done = 0;
        bit  prev_fetch = 1;
        m_cyc = 0; m_soma = 0; m_alu = 0; m_rf = 0; m_wb = 0; m_pcwe = 0;
        m_pcsrc = 0; m_dreq = 0; m_dwe = 0; m_irwe = 0; m_trap = 0; m_timeout = 0;
        opcode = op; funct7 = f7; zero = z; funct3 = 3'b011;
        for (int c = 0; c < 40 && !done; c++) begin
            imem_ack = imem_req ? (icnt >= iw) : spur;
            dmem_ack = dmem_req ? (dcnt >= dw) : spur;
            #1;
            if (c > 0 && imem_req && !prev_fetch) begin
                done = 1;
            end else begin
                m_soma |= int'(soma_ou_subtrai);
                m_alu  |= int'(alu_src);
                m_trap |= int'(trap);
                if (rf_we)    begin m_rf++;   m_wb = int'(wb_sel); end
                if (pc_we)    begin m_pcwe++; m_pcsrc = int'(pc_src); end
                if (dmem_req) begin m_dreq++; m_dwe |= int'(dmem_we); end
                if (ir_we)    m_irwe++;
                prev_fetch = imem_req;
                if (imem_req) icnt++;
                if (dmem_req) dcnt++;
                @(posedge clk);
                @(negedge clk);
                m_cyc++;
            end
        end
        if (!done) m_timeout = 1;
    endtask

    initial begin
        reset = 1'b1;
        opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0; zero = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0;

        //            op          f7          z  iw dw sp cyc so al rf wb pw ps dr dw
        add_vec(7'b0110011, 7'b0000000, 0, 0, 0, 1, 4, 0, 0, 1, 0, 1, 0, 0, 0);
        add_vec(7'b0110011, 7'b0100000, 0, 0, 0, 0, 4, 1, 0, 1, 0, 1, 0, 0, 0);
        add_vec(7'b0010011, 7'b0100000, 0, 0, 0, 0, 4, 0, 1, 1, 0, 1, 0, 0, 0);
        add_vec(7'b0000011, 7'b0000000, 0, 0, 3, 0, 8, 0, 1, 1, 1, 1, 0, 4, 0);
        add_vec(7'b0000011, 7'b0000000, 0, 0, 0, 1, 5, 0, 1, 1, 1, 1, 0, 1, 0);
        add_vec(7'b0100011, 7'b0000000, 0, 0, 0, 1, 4, 0, 1, 0, 0, 1, 0, 1, 1);
        add_vec(7'b0100011, 7'b0000000, 0, 1, 2, 0, 7, 0, 1, 0, 0, 1, 0, 3, 1);
        add_vec(7'b1100011, 7'b0000000, 1, 0, 0, 0, 3, 1, 0, 0, 0, 1, 1, 0, 0);
        add_vec(7'b1100011, 7'b0000000, 0, 0, 0, 1, 3, 1, 0, 0, 0, 1, 0, 0, 0);
        add_vec(7'b1101111, 7'b0000000, 0, 0, 0, 0, 4, 0, 0, 1, 2, 1, 1, 0, 0);
        add_vec(7'b0110011, 7'b0000000, 1, 2, 0, 0, 6, 0, 0, 1, 0, 1, 0, 0, 0);
`ifndef UC_TRAP_EN
        add_vec(7'b1111111, 7'b0000000, 0, 0, 0, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0);
`endif

        @(negedge clk);
        #1;
        check("reset_outs", int'(all_outs), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("first_fetch", int'(imem_req), 1);

        // reset in the middle of a stalled load
        opcode = OP_LD; funct7 = 7'd0; imem_ack = 1'b1; dmem_ack = 1'b0;
        for (int c = 0; c < 10 && !dmem_req; c++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        check("reach_mem", int'(dmem_req), 1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_mem_outs", int'(all_outs), 0);
        check("rst_mid_mem_state", int'(dut.state == IDLE), 1);
        dmem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_hold_outs", int'(all_outs), 0);
        reset = 1'b0;
        #1;
        check("release_idle", int'(imem_req), 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("release_fetch", int'(imem_req), 1);
        check("late_ack_ignored", int'(dmem_req), 0);

        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].f7, vecs[i].z, vecs[i].iw, vecs[i].dw, vecs[i].spur);
            check($sformatf("v%0d_timeout", i), int'(m_timeout), 0);
            check($sformatf("v%0d_cycles", i), m_cyc, vecs[i].cyc);
            check($sformatf("v%0d_soma", i), m_soma, vecs[i].soma);
            check($sformatf("v%0d_alu_src", i), m_alu, vecs[i].alu);
            check($sformatf("v%0d_rf_we", i), m_rf, vecs[i].rf);
            check($sformatf("v%0d_wb_sel", i), m_wb, vecs[i].wb);
            check($sformatf("v%0d_pc_we", i), m_pcwe, vecs[i].pcwe);
            check($sformatf("v%0d_pc_src", i), m_pcsrc, vecs[i].pcsrc);
            check($sformatf("v%0d_dmem_req", i), m_dreq, vecs[i].dreq);
            check($sformatf("v%0d_dmem_we", i), m_dwe, vecs[i].dwe);
            check($sformatf("v%0d_ir_we", i), m_irwe, 1);
            check($sformatf("v%0d_trap", i), m_trap, 0);
        end

`ifdef UC_TRAP_EN
        begin
            int pcwe_seen = 0;
            opcode = 7'b1111111; funct7 = 7'd0; imem_ack = 1'b1; dmem_ack = 1'b1;
            @(posedge clk);
            @(posedge clk);
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                #1;
                if (pc_we) pcwe_seen++;
                check($sformatf("trap_c%0d", c), int'(all_outs), 1);
            end
            check("trap_no_pc_we", pcwe_seen, 0);
            reset = 1'b1;
            #1;
            check("trap_cleared", int'(trap), 0);
            @(negedge clk);
            reset = 1'b0;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
